lsu_axi_master: RTL and testbench

LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

---
 rtl/lsu_axi_master.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
// Load/store unit bridge from a single-outstanding core request port to AXI-lite style
// AR/R and AW/W/B channels, with alignment/type checking and load data extension.
`timescale 1ns/1ps
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_type,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  type_q, type_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        accept, aw_done, w_done;

  function automatic logic req_bad(input logic wen, input logic [2:0] typ, input logic [1:0] off);
    logic illegal;
    logic misal;
    illegal = (typ > 3'd4) || (wen && (typ == 3'd3 || typ == 3'd4));
    misal   = ((typ == 3'd1 || typ == 3'd4) && off[0]) || (typ == 3'd2 && off != 2'b00);
    return illegal || misal;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] data, input logic [1:0] off,
                                           input logic [2:0] typ);
    logic [31:0] sh;
    logic [31:0] res;
    sh = data >> {off, 3'b000};
    case (typ)
      3'd0:    res = {{24{sh[7]}}, sh[7:0]};
      3'd1:    res = {{16{sh[15]}}, sh[15:0]};
      3'd3:    res = {24'd0, sh[7:0]};
      3'd4:    res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] off, input logic [2:0] typ);
    logic [3:0] res;
    case (typ)
      3'd0, 3'd3: res = 4'b0001 << off;
      3'd1, 3'd4: res = 4'b0011 << off;
      default:    res = 4'b1111;
    endcase
    return res;
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // A channel counts as done once its valid is already low or is being accepted now.
  assign aw_done   = !awvalid_q || awready;
  assign w_done    = !wvalid_q || wready;

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    type_d       = type_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d  = req_addr[1:0];
          type_d = req_type;
          if (req_bad(req_wen, req_type, req_addr[1:0])) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (!req_wen) begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
          end else begin
            state_d   = WREQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
            wstrb_d   = store_strb(req_addr[1:0], req_type);
          end
        end
      end
      RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (rvalid) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = rresp;
          resp_rdata_d = load_ext(rdata, off_q, type_q);
          state_d      = DONE;
        end
      end
      WREQ: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (bvalid) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = bresp;
          resp_rdata_d = 32'd0;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= 32'd0;
      awaddr_q     <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Request shape is only consulted while a transaction is in flight.
  always_ff @(posedge clk) begin
    off_q  <= off_d;
    type_q <= type_d;
  end

  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign rready     = rready_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = awaddr_q;
  assign wvalid     = wvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign bready     = bready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed and random load/store transactions against a
// subordinate model with configurable stalls, checked against arithmetic expectations.
`timescale 1ns/1ps
module tb_lsu_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_type;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rresp, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_axi_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte lane selection then sign/zero extension by the load type.
  function automatic logic [31:0] model_load(input logic [31:0] d, input int off, input int typ);
    logic [31:0] sh;
    logic [31:0] v;
    sh = d >> (8 * off);
    case (typ)
      0: begin v = sh % 256;   if (v > 127)   v = v - 256;   end
      1: begin v = sh % 65536; if (v > 32767) v = v - 65536; end
      3: v = sh % 256;
      4: v = sh % 65536;
      default: v = sh;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_type = 0;
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rdata = 0; rresp = 0; bvalid = 0; bresp = 0;
  endtask

  task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                         input int typ, input int ar_st, input int r_st, input int aw_st,
                         input int w_st, input int b_st, input bit early,
                         input logic [31:0] rd, input bit rresp_i, input bit bresp_i,
                         input string tag);
    int off, size, exp_lat, a_c, w_c, ar_vis, aw_vis, w_vis, r_cnt, b_cnt;
    bit bad, exp_err, ar_pend, aw_pend, w_pend, aw_hs, w_hs, seen, finished;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_strb;
    off  = int'(addr % 4);
    size = (typ == 0 || typ == 3) ? 1 : (typ == 1 || typ == 4) ? 2 : 4;
    bad  = (typ > 4) || (wen && typ > 2) || (int'(addr % size) != 0);
    a_c  = early ? 1 : ar_st + 1;
    w_c  = early ? 1 : w_st + 1;
    exp_lat = bad ? 1 : !wen ? 1 + a_c + r_st + 1
                             : 1 + ((early ? 1 : aw_st + 1) > w_c ? (early ? 1 : aw_st + 1) : w_c) + b_st + 1;
    exp_err  = bad ? 1'b1 : wen ? bresp_i : rresp_i;
    exp_rd   = (bad || wen) ? 32'd0 : model_load(rd, off, typ);
    exp_wd   = wd * (32'd1 << (8 * off));
    exp_strb = 4'(((1 << size) - 1) << off);
    ar_vis = 0; aw_vis = 0; w_vis = 0; r_cnt = 0; b_cnt = 0;
    ar_pend = 0; aw_pend = 0; w_pend = 0; aw_hs = 0; w_hs = 0; seen = 0; finished = 0;

    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_type = 3'(typ);
    arready = early; awready = early; wready = early; rvalid = 0; bvalid = 0;
    check({tag, "_req_ready"}, req_ready, 1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      @(negedge clk);
      if (seen) begin
        req_valid = 0;
        check({tag, "_resp_pulse"}, resp_valid, 0);
        check({tag, "_ready_back"}, req_ready, 1);
        finished = 1;
      end else begin
        req_valid = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_wen = 1'($urandom); req_type = 3'($urandom);
        check({tag, "_busy"}, req_ready, 0);
        if (ar_pend) check({tag, "_ar_hold"}, arvalid, 1);
        if (aw_pend) check({tag, "_aw_hold"}, awvalid, 1);
        if (w_pend)  check({tag, "_w_hold"}, wvalid, 1);
        if (arvalid) begin ar_vis++; check({tag, "_araddr"}, araddr, addr); end
        if (awvalid) begin aw_vis++; check({tag, "_awaddr"}, awaddr, addr); end
        if (wvalid) begin
          w_vis++;
          check({tag, "_wdata"}, wdata, exp_wd);
          check({tag, "_wstrb"}, 32'(wstrb), 32'(exp_strb));
        end
        if (bready) check({tag, "_b_after_aw_w"}, 32'(aw_hs && w_hs), 1);
        if (resp_valid) begin
          seen = 1;
          check({tag, "_latency"}, cyc, exp_lat);
          check({tag, "_rdata"}, resp_rdata, exp_rd);
          check({tag, "_err"}, resp_err, exp_err);
        end
        arready = early || (arvalid && ar_vis > ar_st);
        awready = early || (awvalid && aw_vis > aw_st);
        wready  = early || (wvalid && w_vis > w_st);
        ar_pend = arvalid && !arready;
        aw_pend = awvalid && !awready;
        w_pend  = wvalid && !wready;
        if (awvalid && awready) aw_hs = 1;
        if (wvalid && wready)   w_hs = 1;
        if (rready) r_cnt++;
        rvalid = rready && r_cnt > r_st;
        rdata  = rvalid ? rd : $urandom;
        rresp  = rvalid ? rresp_i : 1'($urandom);
        if (bready) b_cnt++;
        bvalid = bready && b_cnt > b_st;
        bresp  = bvalid ? bresp_i : 1'($urandom);
      end
    end
    check({tag, "_completed"}, finished, 1);
    if (bad) begin
      check({tag, "_no_axi"}, ar_vis + aw_vis + w_vis, 0);
    end else if (!early) begin
      if (wen) begin
        check({tag, "_aw_cycles"}, aw_vis, aw_st + 1);
        check({tag, "_w_cycles"}, w_vis, w_st + 1);
      end else begin
        check({tag, "_ar_cycles"}, ar_vis, ar_st + 1);
      end
    end
    idle_inputs();
  endtask

  initial begin
    bit          wen_r, early_r;
    int          typ_r;
    logic [31:0] addr_r;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}, 0);
    check("rst_data", araddr | awaddr | wdata | resp_rdata, 0);
    check("rst_wstrb", wstrb, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    run_txn(0, 32'h8000_0004, 0, 2, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, "ld_word");
    repeat (3) @(negedge clk);
    check("hold_rdata", resp_rdata, 32'hDEADBEEF);
    check("hold_valid", resp_valid, 0);
    run_txn(0, 32'h8000_0003, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80112233, 0, 0, "ld_sbyte");
    check("ld_sbyte_lit", resp_rdata, 32'hFFFFFF80);
    run_txn(0, 32'h8000_0003, 0, 3, 0, 0, 0, 0, 0, 0, 32'h80112233, 0, 0, "ld_ubyte");
    check("ld_ubyte_lit", resp_rdata, 32'h00000080);
    run_txn(0, 32'h8000_0002, 0, 4, 0, 0, 0, 0, 0, 0, 32'h80112233, 0, 0, "ld_uhalf");
    check("ld_uhalf_lit", resp_rdata, 32'h00008011);
    run_txn(1, 32'h8000_0002, 32'h0000ABCD, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, "st_half");
    check("st_rdata_zero", resp_rdata, 0);
    run_txn(1, 32'h8000_0001, 32'h1234_5678, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, "st_misal");
    run_txn(0, 32'h8000_0000, 0, 6, 0, 0, 0, 0, 0, 0, 32'h5555_5555, 0, 0, "ld_type6");
    run_txn(0, 32'h0000_1000, 0, 2, 7, 7, 0, 0, 0, 0, 32'h1234_5678, 1, 0, "ld_stall_err");
    run_txn(1, 32'h0000_2000, 32'hCAFE_F00D, 2, 0, 0, 2, 5, 3, 0, 0, 0, 1, "st_berr");
    run_txn(1, 32'h0000_3003, 32'h0000_00A5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, "st_ubyte_ill");

    for (int i = 0; i < 40; i++) begin
      wen_r   = 1'($urandom);
      typ_r   = int'($urandom_range(0, 7));
      addr_r  = $urandom;
      early_r = ($urandom_range(0, 3) == 0);
      run_txn(wen_r, addr_r, $urandom, typ_r, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              early_r, $urandom, 1'($urandom), 1'($urandom), "rand");
    end

    // Reset while a store is stalled on AW/W must abandon it silently.
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = 32'h0000_0100; req_wdata = 32'h1111_2222; req_type = 2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    check("rst_mid_aw_pending", awvalid, 1);
    rst = 1;
    @(negedge clk);
    check("rst_mid_ready", req_ready, 0);
    check("rst_mid_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
    check("rst_mid_wstrb", wstrb, 0);
    rst = 0;
    @(negedge clk);
    check("rst_mid_ready_after", req_ready, 1);
    check("rst_mid_no_resp", resp_valid, 0);
    @(negedge clk);
    check("rst_mid_no_resp2", resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
